// File: rtl/transform_coder.sv
// 4x4 intra residual coding loop: forward core transform, quantise, de-quantise and inverse
// transform, each held in its own enable-gated register stage.
module transform_coder (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       enabler,
    input  logic [5:0]       QP,
    input  logic [15:0][7:0] residuals,
    output logic [15:0][7:0] processedres
);

    function automatic logic signed [15:0] fwd_coef(
        input logic signed [15:0] x0, x1, x2, x3,
        input logic [1:0]         k
    );
        logic signed [15:0] s0, s1, d0, d1;
        s0 = x0 + x3;
        s1 = x1 + x2;
        d0 = x0 - x3;
        d1 = x1 - x2;
        case (k)
            2'd0:    return s0 + s1;
            2'd1:    return (d0 <<< 1) + d1;
            2'd2:    return s0 - s1;
            default: return d0 - (d1 <<< 1);
        endcase
    endfunction

    function automatic logic signed [31:0] inv_coef(
        input logic signed [31:0] w0, w1, w2, w3,
        input logic [1:0]         k
    );
        logic signed [31:0] e0, e1, e2, e3;
        e0 = w0 + w2;
        e1 = w0 - w2;
        e2 = (w1 >>> 1) - w3;
        e3 = w1 + (w3 >>> 1);
        case (k)
            2'd0:    return e0 + e3;
            2'd1:    return e1 + e2;
            2'd2:    return e1 - e2;
            default: return e0 - e3;
        endcase
    endfunction

    // Position class: 0 = both coordinates even, 1 = both odd, 2 = mixed.
    function automatic logic [1:0] pos_class(input int r, input int c);
        if ((r % 2 == 0) && (c % 2 == 0)) return 2'd0;
        if ((r % 2 == 1) && (c % 2 == 1)) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [13:0] mf_lookup(input logic [1:0] cls, input logic [2:0] rem);
        logic [13:0] a, b, c;
        case (rem)
            3'd0:    begin a = 14'd13107; b = 14'd5243; c = 14'd8066; end
            3'd1:    begin a = 14'd11916; b = 14'd4660; c = 14'd7490; end
            3'd2:    begin a = 14'd10082; b = 14'd4194; c = 14'd6554; end
            3'd3:    begin a = 14'd9362;  b = 14'd3647; c = 14'd5825; end
            3'd4:    begin a = 14'd8192;  b = 14'd3355; c = 14'd5243; end
            default: begin a = 14'd7282;  b = 14'd2893; c = 14'd4559; end
        endcase
        case (cls)
            2'd0:    return a;
            2'd1:    return b;
            default: return c;
        endcase
    endfunction

    function automatic logic [4:0] v_lookup(input logic [1:0] cls, input logic [2:0] rem);
        logic [4:0] a, b, c;
        case (rem)
            3'd0:    begin a = 5'd10; b = 5'd16; c = 5'd13; end
            3'd1:    begin a = 5'd11; b = 5'd18; c = 5'd14; end
            3'd2:    begin a = 5'd13; b = 5'd20; c = 5'd16; end
            3'd3:    begin a = 5'd14; b = 5'd23; c = 5'd18; end
            3'd4:    begin a = 5'd16; b = 5'd25; c = 5'd20; end
            default: begin a = 5'd18; b = 5'd29; c = 5'd23; end
        endcase
        case (cls)
            2'd0:    return a;
            2'd1:    return b;
            default: return c;
        endcase
    endfunction

    function automatic logic signed [15:0] quantise(
        input logic signed [15:0] w,
        input logic [13:0]        mf,
        input logic [31:0]        f,
        input logic [4:0]         qbits
    );
        logic [31:0] mag, q;
        mag = w[15] ? 32'(-w) : 32'(w);
        q   = (mag * {18'd0, mf} + f) >> qbits;
        return w[15] ? -16'(q) : 16'(q);
    endfunction

    function automatic logic signed [19:0] dequant(
        input logic signed [15:0] z,
        input logic [4:0]         v,
        input logic [3:0]         per
    );
        logic signed [31:0] p;
        p = 32'(z) * $signed({27'd0, v});
        return 20'(p <<< per);
    endfunction

    function automatic logic [7:0] sat_round(input logic signed [31:0] x);
        logic signed [31:0] y;
        y = (x + 32'sd32) >>> 6;
        if (y > 32'sd127)  return 8'h7f;
        if (y < -32'sd128) return 8'h80;
        return y[7:0];
    endfunction

    logic [5:0]  w_qp;
    logic [3:0]  w_per;
    logic [2:0]  w_rem;
    logic [4:0]  w_qbits;
    logic [31:0] w_f;

    logic signed [15:0] w_x  [4][4];
    logic signed [15:0] w_t  [4][4];
    logic signed [15:0] w_fw [4][4];
    logic signed [15:0] w_z  [4][4];
    logic signed [19:0] w_dq [4][4];
    logic signed [31:0] w_ir [4][4];
    logic signed [31:0] w_ic [4][4];
    logic [15:0][7:0]   w_y;

    logic signed [15:0] r_w  [4][4];
    logic signed [15:0] r_z  [4][4];
    logic signed [19:0] r_wq [4][4];
    logic [15:0][7:0]   r_out;

    assign w_qp    = (QP > 6'd51) ? 6'd51 : QP;
    assign w_per   = 4'(w_qp / 6'd6);
    assign w_rem   = 3'(w_qp % 6'd6);
    assign w_qbits = 5'd15 + {1'b0, w_per};
    // 0x55555555 is (2^32-1)/3, so shifting it down yields floor(2^qbits/3) without a divider.
    assign w_f     = 32'h5555_5555 >> (6'd32 - {1'b0, w_qbits});

    // NOTE: every element of each combinational array is written on every pass, so no latch forms.
    always_comb begin
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                w_x[r][c] = 16'($signed(residuals[15 - (4 * r + c)]));
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
                w_t[k][c] = fwd_coef(w_x[0][c], w_x[1][c], w_x[2][c], w_x[3][c], 2'(k));
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                w_fw[r][k] = fwd_coef(w_t[r][0], w_t[r][1], w_t[r][2], w_t[r][3], 2'(k));
    end

    always_comb begin
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                w_z[r][c]  = quantise(r_w[r][c], mf_lookup(pos_class(r, c), w_rem), w_f, w_qbits);
                w_dq[r][c] = dequant(r_z[r][c], v_lookup(pos_class(r, c), w_rem), w_per);
            end
    end

    always_comb begin
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                w_ir[r][k] = inv_coef(32'(r_wq[r][0]), 32'(r_wq[r][1]),
                                      32'(r_wq[r][2]), 32'(r_wq[r][3]), 2'(k));
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
                w_ic[k][c] = inv_coef(w_ir[0][c], w_ir[1][c], w_ir[2][c], w_ir[3][c], 2'(k));
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                w_y[15 - (4 * r + c)] = sat_round(w_ic[r][c]);
    end

    // NOTE: these arrays are pipeline flops, not RAM, so they are cleared by reset like any register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_w   <= '{default: '0};
            r_z   <= '{default: '0};
            r_wq  <= '{default: '0};
            r_out <= '0;
        end else begin
            // NOTE: non-blocking updates let each stage take the previous stage's old value.
            if (enabler[0]) r_w   <= w_fw;
            if (enabler[1]) r_z   <= w_z;
            if (enabler[2]) r_wq  <= w_dq;
            if (enabler[3]) r_out <= w_y;
        end
    end

    assign processedres = r_out;

endmodule

// File: tb/tb_transform_coder.sv
// Directed bench for transform_coder: a behavioural matrix model fills a scoreboard queue
// when a block is launched, and the queue is drained when the last stage fires.
module tb_transform_coder;

    typedef logic [15:0][7:0] blk_t;

    logic       clk;
    logic       reset;
    logic [3:0] enabler;
    logic [5:0] QP;
    blk_t       residuals;
    blk_t       processedres;

    blk_t exp_q[$];
    blk_t last_out;
    int   n_vec;
    int   n_fail;

    transform_coder dut (
        .clk          (clk),
        .reset        (reset),
        .enabler      (enabler),
        .QP           (QP),
        .residuals    (residuals),
        .processedres (processedres)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference: explicit matrix products for the forward path, integer quant/dequant.
    function automatic blk_t model(input blk_t res, input int qp_in);
        int   cf [4][4];
        int   mft [3][6];
        int   vt [3][6];
        int   x [4][4];
        int   w [4][4];
        int   wd [4][4];
        int   t [4][4];
        int   o [4][4];
        int   qp, per, rem, qbits, f, cls, mag, q, z, y;
        int   a0, a1, a2, a3;
        blk_t out;
        cf  = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
        mft = '{'{13107, 11916, 10082, 9362, 8192, 7282},
                '{5243, 4660, 4194, 3647, 3355, 2893},
                '{8066, 7490, 6554, 5825, 5243, 4559}};
        vt  = '{'{10, 11, 13, 14, 16, 18}, '{16, 18, 20, 23, 25, 29}, '{13, 14, 16, 18, 20, 23}};
        qp    = (qp_in > 51) ? 51 : qp_in;
        per   = qp / 6;
        rem   = qp % 6;
        qbits = 15 + per;
        f     = (1 << qbits) / 3;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                x[r][c] = int'($signed(res[15 - (4 * r + c)]));
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                w[i][j] = 0;
                for (int k = 0; k < 4; k++)
                    for (int l = 0; l < 4; l++)
                        w[i][j] += cf[i][k] * x[k][l] * cf[j][l];
            end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (r % 2 == 0 && c % 2 == 0)      cls = 0;
                else if (r % 2 == 1 && c % 2 == 1) cls = 1;
                else                               cls = 2;
                mag = (w[r][c] < 0) ? -w[r][c] : w[r][c];
                q   = (mag * mft[cls][rem] + f) >>> qbits;
                z   = (w[r][c] < 0) ? -q : q;
                wd[r][c] = z * vt[cls][rem] * (1 << per);
            end
        for (int r = 0; r < 4; r++) begin
            a0 = wd[r][0] + wd[r][2];
            a1 = wd[r][0] - wd[r][2];
            a2 = (wd[r][1] >>> 1) - wd[r][3];
            a3 = wd[r][1] + (wd[r][3] >>> 1);
            t[r][0] = a0 + a3; t[r][1] = a1 + a2; t[r][2] = a1 - a2; t[r][3] = a0 - a3;
        end
        for (int c = 0; c < 4; c++) begin
            a0 = t[0][c] + t[2][c];
            a1 = t[0][c] - t[2][c];
            a2 = (t[1][c] >>> 1) - t[3][c];
            a3 = t[1][c] + (t[3][c] >>> 1);
            o[0][c] = a0 + a3; o[1][c] = a1 + a2; o[2][c] = a1 - a2; o[3][c] = a0 - a3;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                y = (o[r][c] + 32) >>> 6;
                if (y > 127)  y = 127;
                if (y < -128) y = -128;
                out[15 - (4 * r + c)] = 8'(y);
            end
        return out;
    endfunction

    task automatic check(input string tag, input blk_t obs, input blk_t exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] en);
        enabler = en;
        @(posedge clk);
        #1;
        enabler = 4'd0;
    endtask

    task automatic pop_and_check(input string tag);
        blk_t exp;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $error("FAIL %s: observed=output expected=queued entry (scoreboard empty)", tag);
        end else begin
            exp = exp_q.pop_front();
            check(tag, processedres, exp);
            last_out = exp;
        end
    endtask

    // One block through the rotating one-hot enables; the output must hold until the en[3] edge.
    task automatic run_block(input string tag, input blk_t res, input int qp,
                             input bit chk_int, input int w00, input int z00, input int wq00);
        residuals = res;
        QP        = 6'(qp);
        exp_q.push_back(model(res, qp));
        pulse(4'b0001);
        if (chk_int) check_int({tag, "_w00"}, int'(dut.r_w[0][0]), w00);
        check({tag, "_hold1"}, processedres, last_out);
        pulse(4'b0010);
        if (chk_int) check_int({tag, "_z00"}, int'(dut.r_z[0][0]), z00);
        pulse(4'b0100);
        if (chk_int) check_int({tag, "_wq00"}, int'(dut.r_wq[0][0]), wq00);
        check({tag, "_hold3"}, processedres, last_out);
        pulse(4'b1000);
        pop_and_check({tag, "_out"});
    endtask

    task automatic rand_blk(output blk_t b);
        for (int k = 0; k < 16; k++) b[k] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        blk_t b0, b10, bm128, bx, bcheck;
        int   qps [7];
        n_vec     = 0;
        n_fail    = 0;
        last_out  = '0;
        b0        = '0;
        b10       = {16{8'd10}};
        bm128     = {16{8'h80}};
        reset     = 1'b0;
        enabler   = 4'd0;
        QP        = 6'd0;
        residuals = '0;

        // T1: reset clears, and output stays clear after release with no enables.
        repeat (2) @(posedge clk);
        #1;
        check("t1_in_reset", processedres, b0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t1_after_release", processedres, b0);

        // T2/T3/T4: directed blocks from the block description.
        run_block("t2_zero", b0, 2, 1'b1, 0, 0, 0);
        run_block("t3_ten", b10, 2, 1'b1, 160, 49, 637);
        check("t3_all_ten", processedres, b10);

        // T5: output holds while residuals wander with no enables.
        for (int i = 0; i < 5; i++) begin
            rand_blk(bx);
            residuals = bx;
            @(posedge clk);
            #1;
            check("t5_hold", processedres, b10);
        end

        run_block("t4_m128", bm128, 2, 1'b1, -2048, -630, -8190);
        check("t4_all_m128", processedres, bm128);

        // Random blocks across the QP range, including the clamp above 51.
        qps = '{0, 5, 6, 17, 30, 51, 63};
        foreach (qps[i]) begin
            rand_blk(bx);
            run_block($sformatf("rand_qp%0d", qps[i]), bx, qps[i], 1'b0, 0, 0, 0);
        end

        // Alternating extremes at coarse quantisation, stressing rounding and saturation.
        for (int k = 0; k < 16; k++) bcheck[k] = (((k / 4) + k) % 2 == 0) ? 8'h7f : 8'h80;
        run_block("sat_qp51", bcheck, 51, 1'b0, 0, 0, 0);
        run_block("sat_qp40", bcheck, 40, 1'b0, 0, 0, 0);

        // All enables together: each stage takes the prior stage's registered value.
        rand_blk(bx);
        residuals = bx;
        QP        = 6'd28;
        exp_q.push_back(model(bx, 28));
        enabler = 4'b1111;
        repeat (4) @(posedge clk);
        #1;
        enabler = 4'd0;
        pop_and_check("all_en_out");

        // T6: reset mid-block clears immediately and the block is discarded.
        run_block("t6_pre", b10, 2, 1'b0, 0, 0, 0);
        residuals = b10;
        QP        = 6'd2;
        pulse(4'b0001);
        pulse(4'b0010);
        reset = 1'b0;
        #2;
        check("t6_async_clear", processedres, b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        pulse(4'b0100);
        pulse(4'b1000);
        check("t6_out", processedres, b0);
        last_out = b0;

        n_vec++;
        assert (exp_q.size() == 0)
        else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed=%0d entries expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
